// File: rtl/alu_result_stage.sv
// ALU result stage: 2-entry skid buffer feeding register-file writeback, plus in-order APSR N/Z commit.
// Optional forwarding outputs are built when ALU_RESULT_FWD_EN is defined.
package arm_cortex_m0p_pkg;
    localparam int unsigned DATA_WIDTH = 32;
endpackage

module alu_result_stage
    import arm_cortex_m0p_pkg::*;
#(
    parameter int unsigned RD_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_result,
    input  logic                  in_z,
    input  logic                  in_n,
    input  logic [RD_WIDTH-1:0]   in_rd,
    input  logic                  in_rd_we,
    input  logic                  in_set_flags,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [RD_WIDTH-1:0]   out_rd,
    output logic                  out_rd_we,
    output logic                  apsr_n,
    output logic                  apsr_z,
    output logic [1:0]            occupancy
`ifdef ALU_RESULT_FWD_EN
    ,
    output logic                  fwd_valid,
    output logic [RD_WIDTH-1:0]   fwd_rd,
    output logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  fwd_n,
    output logic                  fwd_z
`endif
);

    logic                  r_head_valid;
    logic [DATA_WIDTH-1:0] r_head_result;
    logic [RD_WIDTH-1:0]   r_head_rd;
    logic                  r_head_we;
    logic                  r_head_sf;
    logic                  r_head_n;
    logic                  r_head_z;

    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_result;
    logic [RD_WIDTH-1:0]   r_skid_rd;
    logic                  r_skid_we;
    logic                  r_skid_sf;
    logic                  r_skid_n;
    logic                  r_skid_z;

    logic                  r_apsr_n;
    logic                  r_apsr_z;

    logic                  w_accept;
    logic                  w_retire;

    assign in_ready   = !r_skid_valid;
    assign w_accept   = in_valid && in_ready;
    assign w_retire   = r_head_valid && out_ready;

    assign out_valid  = r_head_valid;
    assign out_result = r_head_result;
    assign out_rd     = r_head_rd;
    assign out_rd_we  = r_head_we;
    assign apsr_n     = r_apsr_n;
    assign apsr_z     = r_apsr_z;
    // Skid is only ever valid behind a valid head, so occupancy needs no adder.
    assign occupancy  = {r_skid_valid, r_head_valid & ~r_skid_valid};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_valid  <= 1'b0;
            r_head_result <= '0;
            r_head_rd     <= '0;
            r_head_we     <= 1'b0;
            r_head_sf     <= 1'b0;
            r_head_n      <= 1'b0;
            r_head_z      <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_result <= '0;
            r_skid_rd     <= '0;
            r_skid_we     <= 1'b0;
            r_skid_sf     <= 1'b0;
            r_skid_n      <= 1'b0;
            r_skid_z      <= 1'b0;
            r_apsr_n      <= 1'b0;
            r_apsr_z      <= 1'b0;
        end else begin
            // A retiring head commits its flags even when a flush lands on the same edge.
            if (w_retire && r_head_sf) begin
                r_apsr_n <= r_head_n;
                r_apsr_z <= r_head_z;
            end

            if (flush) begin
                r_head_valid <= 1'b0;
                r_skid_valid <= 1'b0;
            end else if (w_retire) begin
                if (r_skid_valid) begin
                    r_head_result <= r_skid_result;
                    r_head_rd     <= r_skid_rd;
                    r_head_we     <= r_skid_we;
                    r_head_sf     <= r_skid_sf;
                    r_head_n      <= r_skid_n;
                    r_head_z      <= r_skid_z;
                    r_skid_valid  <= 1'b0;
                end else if (w_accept) begin
                    r_head_result <= in_result;
                    r_head_rd     <= in_rd;
                    r_head_we     <= in_rd_we;
                    r_head_sf     <= in_set_flags;
                    r_head_n      <= in_n;
                    r_head_z      <= in_z;
                end else begin
                    r_head_valid  <= 1'b0;
                end
            end else if (w_accept) begin
                if (!r_head_valid) begin
                    r_head_valid  <= 1'b1;
                    r_head_result <= in_result;
                    r_head_rd     <= in_rd;
                    r_head_we     <= in_rd_we;
                    r_head_sf     <= in_set_flags;
                    r_head_n      <= in_n;
                    r_head_z      <= in_z;
                end else begin
                    r_skid_valid  <= 1'b1;
                    r_skid_result <= in_result;
                    r_skid_rd     <= in_rd;
                    r_skid_we     <= in_rd_we;
                    r_skid_sf     <= in_set_flags;
                    r_skid_n      <= in_n;
                    r_skid_z      <= in_z;
                end
            end
        end
    end

`ifdef ALU_RESULT_FWD_EN
    // Youngest matching entry wins: skid is younger than head.
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = '0;
        fwd_data  = '0;
        if (r_skid_valid && r_skid_we) begin
            fwd_valid = 1'b1;
            fwd_rd    = r_skid_rd;
            fwd_data  = r_skid_result;
        end else if (r_head_valid && r_head_we) begin
            fwd_valid = 1'b1;
            fwd_rd    = r_head_rd;
            fwd_data  = r_head_result;
        end

        fwd_n = r_apsr_n;
        fwd_z = r_apsr_z;
        if (r_skid_valid && r_skid_sf) begin
            fwd_n = r_skid_n;
            fwd_z = r_skid_z;
        end else if (r_head_valid && r_head_sf) begin
            fwd_n = r_head_n;
            fwd_z = r_head_z;
        end
    end
`endif

endmodule
